// File: rtl/ffe_lms_engine.sv
// rtl/ffe_lms_engine.sv - lane-serial LMS coefficient update engine for an FFE
//
// Purpose: accepts one (x, fir, slicer, mu, mode) sample set while idle, sweeps
// the tap bank LANES taps per cycle into a shadow bank, then commits the whole
// shadow bank to the active (visible) bank in a single edge.
//
// Ports:
//   i_clock            sole clock
//   i_reset            asynchronous active-low reset
//   i_valid / o_ready  sample-set handshake (o_ready high only in IDLE)
//   i_fir_out          signed FFE output, NB_I bits, NBF_I fractional
//   i_slicer_out       signed decision, NB_I bits, NBF_I fractional
//   i_xk_flat          signed regressor, FFE_LEN x NB_I, index FFE_LEN-1 newest
//   i_mu               signed step size, NB_MU bits, NBF_MU fractional
//   i_mode             00 LMS, 01 sign-error, 10 sign-sign, 11 hold
//   i_load             load i_coeff_init_flat into both banks (IDLE only)
//   i_coeff_init_flat  load value, FFE_LEN x NB
//   o_coeff_flat       active coefficient bank, FFE_LEN x NB (registered)
//   o_done             one-cycle pulse when a new bank becomes visible
//   o_drop_cnt         saturating count of dropped sample sets
//
// Configuration: define LMS_LEAKAGE_EN to add the leakage term
// w - (w >>> LEAK_SHIFT) in modes 00-10.

module ffe_lms_engine #(
   parameter int NB_I       = 18,
   parameter int NBF_I      = 15,
   parameter int FFE_LEN    = 21,
   parameter int NB         = 8,
   parameter int NBF        = 7,
   parameter int NB_MU      = 16,
   parameter int NBF_MU     = 15,
   parameter int LANES      = 3,
   parameter int LEAK_SHIFT = 4,
   parameter int NB_DROP    = 16
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic signed [NB_I-1:0]    i_fir_out,
   input  logic signed [NB_I-1:0]    i_slicer_out,
   input  logic [NB_I*FFE_LEN-1:0]   i_xk_flat,
   input  logic signed [NB_MU-1:0]   i_mu,
   input  logic [1:0]                i_mode,
   input  logic                      i_load,
   input  logic [NB*FFE_LEN-1:0]     i_coeff_init_flat,
   output logic [NB*FFE_LEN-1:0]     o_coeff_flat,
   output logic                      o_done,
   output logic [NB_DROP-1:0]        o_drop_cnt
);

   localparam int NSTEPS = (FFE_LEN + LANES - 1) / LANES;
   localparam int SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
   // Shift that brings mu*e*x (NBF_MU + 2*NBF_I fractional) to coefficient scale.
   localparam int S      = NBF_MU + 2*NBF_I - NBF;
   localparam int NE     = NB_I + 1;
   // Full product width plus headroom for the rounding add and the subtraction.
   localparam int NA     = NB_MU + NE + NB_I + 2;

   localparam logic signed [NE-1:0]   E_ONE = {{(NE-NBF_I-1){1'b0}}, 1'b1, {NBF_I{1'b0}}};
   localparam logic signed [NB_I-1:0] X_ONE = {{(NB_I-NBF_I-1){1'b0}}, 1'b1, {NBF_I{1'b0}}};
   localparam logic signed [NA-1:0]   HALF  = {{(NA-S){1'b0}}, 1'b1, {(S-1){1'b0}}};
   localparam logic signed [NA-1:0]   W_MAX = {{(NA-NB+1){1'b0}}, {(NB-1){1'b1}}};
   localparam logic signed [NA-1:0]   W_MIN = {{(NA-NB+1){1'b1}}, {(NB-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

   state_t                   state;
   logic [SW-1:0]            step;
   logic [NB_I*FFE_LEN-1:0]  x_q;
   logic signed [NE-1:0]     e_q;
   logic signed [NB_MU-1:0]  mu_q;
   logic [1:0]               mode_q;
   logic [NB*FFE_LEN-1:0]    shadow;
   logic [NB*FFE_LEN-1:0]    shadow_nxt;
   logic [NB*FFE_LEN-1:0]    active;
   logic signed [NE-1:0]     e_in;

   // Error is formed one bit wider so fir - slicer can never wrap.
   assign e_in = $signed({i_fir_out[NB_I-1], i_fir_out}) - $signed({i_slicer_out[NB_I-1], i_slicer_out});

   function automatic logic [NB-1:0] tap_next(
      input logic signed [NB-1:0]    w,
      input logic signed [NB_I-1:0]  xv,
      input logic signed [NE-1:0]    ev,
      input logic signed [NB_MU-1:0] mv,
      input logic [1:0]              md
   );
      logic signed [NE-1:0]   ep;
      logic signed [NB_I-1:0] xp;
      logic signed [NA-1:0]   prod;
      logic signed [NA-1:0]   delta;
      logic signed [NA-1:0]   wext;
      logic signed [NA-1:0]   acc;
      logic [NB-1:0]          res;
      if (md == 2'b00)
         ep = ev;
      else
         ep = (ev == '0) ? '0 : (ev[NE-1] ? -E_ONE : E_ONE);
      if (md == 2'b10)
         xp = (xv == '0) ? '0 : (xv[NB_I-1] ? -X_ONE : X_ONE);
      else
         xp = xv;
      // Operands sign-extended to NA so the low NA bits hold the exact product.
      prod  = $signed({{(NA-NB_MU){mv[NB_MU-1]}}, mv})
            * $signed({{(NA-NE){ep[NE-1]}}, ep})
            * $signed({{(NA-NB_I){xp[NB_I-1]}}, xp});
      delta = (prod + HALF) >>> S;
      wext  = $signed({{(NA-NB){w[NB-1]}}, w});
`ifdef LMS_LEAKAGE_EN
      acc   = wext - (wext >>> LEAK_SHIFT) - delta;
`else
      acc   = wext - delta;
`endif
      if (md == 2'b11)
         res = w;
      else if (acc > W_MAX)
         res = W_MAX[NB-1:0];
      else if (acc < W_MIN)
         res = W_MIN[NB-1:0];
      else
         res = acc[NB-1:0];
      return res;
   endfunction

   // Taps of the current step; lanes past the last tap are left untouched.
   always_comb begin
      shadow_nxt = shadow;
      for (int l = 0; l < LANES; l++) begin
         int idx;
         idx = int'(step) * LANES + l;
         if (idx < FFE_LEN)
            shadow_nxt[idx*NB +: NB] = tap_next(shadow[idx*NB +: NB], x_q[idx*NB_I +: NB_I],
                                                e_q, mu_q, mode_q);
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state      <= IDLE;
         step       <= '0;
         x_q        <= '0;
         e_q        <= '0;
         mu_q       <= '0;
         mode_q     <= '0;
         shadow     <= '0;
         active     <= '0;
         o_done     <= 1'b0;
         o_drop_cnt <= '0;
      end else begin
         o_done <= 1'b0;
         if (i_valid && (state != IDLE || i_load) && o_drop_cnt != '1)
            o_drop_cnt <= o_drop_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (i_load) begin
                  shadow <= i_coeff_init_flat;
                  active <= i_coeff_init_flat;
               end else if (i_valid) begin
                  x_q    <= i_xk_flat;
                  e_q    <= e_in;
                  mu_q   <= i_mu;
                  mode_q <= i_mode;
                  step   <= '0;
                  state  <= UPDATE;
               end
            end
            UPDATE: begin
               shadow <= shadow_nxt;
               if (step == SW'(NSTEPS - 1))
                  state <= COMMIT;
               else
                  step <= step + 1'b1;
            end
            COMMIT: begin
               active <= shadow;
               o_done <= 1'b1;
               step   <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_ready      = (state == IDLE);
   assign o_coeff_flat = active;

endmodule

// File: tb/tb_ffe_lms_engine.sv
// tb/tb_ffe_lms_engine.sv - self-checking bench for ffe_lms_engine

module tb_ffe_lms_engine;

   localparam int NB_I    = 18;
   localparam int NBF_I   = 15;
   localparam int FFE_LEN = 21;
   localparam int NB      = 8;
   localparam int NBF     = 7;
   localparam int NB_MU   = 16;
   localparam int NBF_MU  = 15;
   localparam int LANES   = 3;
   localparam int LEAK    = 4;
   localparam int NB_DROP = 16;
   localparam int S       = NBF_MU + 2*NBF_I - NBF;
   localparam int LAT     = (FFE_LEN + LANES - 1) / LANES + 1;

   logic                     i_clock = 1'b0;
   logic                     i_reset = 1'b0;
   logic                     i_valid = 1'b0;
   logic                     o_ready;
   logic signed [NB_I-1:0]   i_fir_out = '0;
   logic signed [NB_I-1:0]   i_slicer_out = '0;
   logic [NB_I*FFE_LEN-1:0]  i_xk_flat = '0;
   logic signed [NB_MU-1:0]  i_mu = '0;
   logic [1:0]               i_mode = '0;
   logic                     i_load = 1'b0;
   logic [NB*FFE_LEN-1:0]    i_coeff_init_flat = '0;
   logic [NB*FFE_LEN-1:0]    o_coeff_flat;
   logic                     o_done;
   logic [NB_DROP-1:0]       o_drop_cnt;

   int checks = 0;
   int failures = 0;
   int w_model [FFE_LEN];
   int x_vals [FFE_LEN];
   int drop_model = 0;
   logic [NB*FFE_LEN-1:0] exp_flat;

   ffe_lms_engine #(
      .NB_I(NB_I), .NBF_I(NBF_I), .FFE_LEN(FFE_LEN), .NB(NB), .NBF(NBF),
      .NB_MU(NB_MU), .NBF_MU(NBF_MU), .LANES(LANES), .LEAK_SHIFT(LEAK), .NB_DROP(NB_DROP)
   ) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_fir_out(i_fir_out), .i_slicer_out(i_slicer_out), .i_xk_flat(i_xk_flat),
      .i_mu(i_mu), .i_mode(i_mode), .i_load(i_load), .i_coeff_init_flat(i_coeff_init_flat),
      .o_coeff_flat(o_coeff_flat), .o_done(o_done), .o_drop_cnt(o_drop_cnt)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [NB*FFE_LEN-1:0] obs, input logic [NB*FFE_LEN-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sgn_unit(int v);
      return (v > 0) ? (1 << NBF_I) : ((v < 0) ? -(1 << NBF_I) : 0);
   endfunction

   function automatic int ref_tap(int w, int e, int x, int mu, int md);
      longint p, d, r;
      int ep, xp;
      if (md == 3) return w;
      ep = (md == 0) ? e : sgn_unit(e);
      xp = (md == 2) ? sgn_unit(x) : x;
      p = longint'(mu) * longint'(ep) * longint'(xp);
      d = (p + (longint'(1) << (S - 1))) >>> S;
      r = longint'(w) - d;
`ifdef LMS_LEAKAGE_EN
      r = r - longint'(w >>> LEAK);
`endif
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return int'(r);
   endfunction

   function automatic logic [NB*FFE_LEN-1:0] model_flat();
      logic [NB*FFE_LEN-1:0] f;
      for (int t = 0; t < FFE_LEN; t++) f[t*NB +: NB] = NB'(w_model[t]);
      return f;
   endfunction

   function automatic int rnd_signed(int bits);
      return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
   endfunction

   task automatic scramble_inputs();
      i_fir_out    = NB_I'(rnd_signed(NB_I));
      i_slicer_out = NB_I'(rnd_signed(NB_I));
      i_mu         = NB_MU'(rnd_signed(NB_MU));
      i_mode       = 2'($urandom_range(0, 3));
      for (int t = 0; t < FFE_LEN; t++) i_xk_flat[t*NB_I +: NB_I] = NB_I'(rnd_signed(NB_I));
   endtask

   task automatic load_bank(input int val_of [FFE_LEN], input bit with_valid);
      logic [NB*FFE_LEN-1:0] f;
      @(negedge i_clock);
      for (int t = 0; t < FFE_LEN; t++) f[t*NB +: NB] = NB'(val_of[t]);
      i_coeff_init_flat = f;
      i_load  = 1'b1;
      i_valid = with_valid;
      @(posedge i_clock); #1;
      i_load  = 1'b0;
      i_valid = 1'b0;
      for (int t = 0; t < FFE_LEN; t++) w_model[t] = val_of[t];
      if (with_valid) drop_model++;
      chk("load_coeff", o_coeff_flat, f);
      chk("load_ready", o_ready, 1'b1);
      chk("load_no_done", o_done, 1'b0);
   endtask

   task automatic run_sweep(input int fir, input int slicer, input int mu, input int md, input int n_drops);
      logic [NB*FFE_LEN-1:0] prev;
      int lat;
      bit got;
      prev = model_flat();
      @(negedge i_clock);
      i_fir_out    = NB_I'(fir);
      i_slicer_out = NB_I'(slicer);
      i_mu         = NB_MU'(mu);
      i_mode       = 2'(md);
      for (int t = 0; t < FFE_LEN; t++) i_xk_flat[t*NB_I +: NB_I] = NB_I'(x_vals[t]);
      i_valid = 1'b1;
      @(posedge i_clock); #1;
      chk("busy_after_accept", o_ready, 1'b0);
      for (int t = 0; t < FFE_LEN; t++) w_model[t] = ref_tap(w_model[t], fir - slicer, x_vals[t], mu, md);
      drop_model += n_drops;
      scramble_inputs();
      i_valid = (n_drops > 0);
      lat = 0;
      got = 1'b0;
      for (int n = 1; n <= 20 && !got; n++) begin
         @(posedge i_clock); #1;
         lat = n;
         if (n == LAT - 1) chk("coeff_not_early", o_coeff_flat, prev);
         if (o_done) got = 1'b1;
         i_valid = (n < n_drops);
         scramble_inputs();
      end
      i_valid = 1'b0;
      chk("done_latency", lat, LAT);
      exp_flat = model_flat();
      chk("coeff_after_sweep", o_coeff_flat, exp_flat);
      @(posedge i_clock); #1;
      chk("done_one_cycle", o_done, 1'b0);
      chk("ready_after_sweep", o_ready, 1'b1);
   endtask

   initial begin
      int vals [FFE_LEN];
      int any_done;

      repeat (2) @(posedge i_clock);
      #1;
      chk("rst_ready", o_ready, 1'b1);
      chk("rst_coeff", o_coeff_flat, '0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_drop", o_drop_cnt, '0);
      @(negedge i_clock);
      i_reset = 1'b1;
      for (int t = 0; t < FFE_LEN; t++) begin w_model[t] = 0; x_vals[t] = 16384; end

      run_sweep(24576, 32768, 16384, 0, 0);
      exp_flat = {FFE_LEN{8'sd8}};
      chk("lms_taps_8", o_coeff_flat, exp_flat);

      for (int t = 0; t < FFE_LEN; t++) vals[t] = 0;
      load_bank(vals, 1'b0);
      run_sweep(24576, 32768, 16384, 1, 0);
      exp_flat = {FFE_LEN{8'sd32}};
      chk("sign_err_taps_32", o_coeff_flat, exp_flat);

      run_sweep(24576, 32768, 16384, 3, 0);
      chk("hold_taps_32", o_coeff_flat, exp_flat);

      for (int t = 0; t < FFE_LEN; t++) vals[t] = 120;
      load_bank(vals, 1'b0);
      run_sweep(24576, 32768, 16384, 2, 0);
      exp_flat = {FFE_LEN{8'sd127}};
      chk("sign_sign_sat_127", o_coeff_flat, exp_flat);

      for (int t = 0; t < FFE_LEN; t++) vals[t] = 0;
      load_bank(vals, 1'b0);
      run_sweep(24576, 32768, 16384, 0, 3);
      exp_flat = {FFE_LEN{8'sd8}};
      chk("drop_first_only", o_coeff_flat, exp_flat);
      chk("drop_cnt_3", o_drop_cnt, NB_DROP'(3));

      load_bank(vals, 1'b1);
      chk("drop_cnt_load", o_drop_cnt, NB_DROP'(drop_model));

`ifdef LMS_LEAKAGE_EN
      for (int t = 0; t < FFE_LEN; t++) vals[t] = 64;
      load_bank(vals, 1'b0);
      run_sweep(24576, 32768, 0, 0, 0);
      exp_flat = {FFE_LEN{8'sd60}};
      chk("leak_taps_60", o_coeff_flat, exp_flat);
`endif

      for (int k = 0; k < 14; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int t = 0; t < FFE_LEN; t++) vals[t] = rnd_signed(NB);
            load_bank(vals, 1'(($urandom_range(0, 1))));
         end
         for (int t = 0; t < FFE_LEN; t++) x_vals[t] = rnd_signed(NB_I);
         run_sweep(rnd_signed(NB_I), rnd_signed(NB_I),
                   ($urandom_range(0, 1) == 1) ? rnd_signed(NB_MU) : rnd_signed(8),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         chk("rand_drop_cnt", o_drop_cnt, NB_DROP'(drop_model));
      end

      @(negedge i_clock);
      for (int t = 0; t < FFE_LEN; t++) i_xk_flat[t*NB_I +: NB_I] = NB_I'(16384);
      i_fir_out = NB_I'(24576); i_slicer_out = NB_I'(32768); i_mu = NB_MU'(16384); i_mode = 2'b00;
      i_valid = 1'b1;
      @(posedge i_clock); #1;
      i_valid = 1'b0;
      repeat (3) @(posedge i_clock);
      #1;
      i_reset = 1'b0;
      #1;
      chk("midrst_coeff", o_coeff_flat, '0);
      chk("midrst_ready", o_ready, 1'b1);
      chk("midrst_drop", o_drop_cnt, '0);
      @(negedge i_clock);
      i_reset = 1'b1;
      any_done = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge i_clock); #1;
         if (o_done) any_done++;
      end
      chk("midrst_no_done", any_done, 0);
      chk("midrst_coeff_stays", o_coeff_flat, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
